// File: rtl/grid_display_tx.sv
// Serial LED-matrix transmitter: shifts one 8-bit row at a time into a column
// register, latches it, then lights that row; refreshes from a captured 64-bit frame.
module grid_display_tx #(
  parameter int CLK_DIV = 4,
  parameter int DWELL   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [63:0] grid_in,
  input  logic        grid_valid,
  output logic        grid_ready,
  output logic        sclk,
  output logic        sdata,
  output logic        slatch,
  output logic [7:0]  row_sel,
  output logic        busy,
  output logic        frame_done
);

  localparam int MAXC = (2 * CLK_DIV > DWELL) ? 2 * CLK_DIV : DWELL;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_DWELL,
    S_FRAME_END
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   buf_q, buf_d;
  logic          sclk_q, sclk_d;
  logic          sdata_q, sdata_d;
  logic          slatch_q, slatch_d;
  logic [7:0]    row_sel_q, row_sel_d;
  logic          capture;

  // reset gates ready so nothing is offered while the block is held in reset
  assign grid_ready = reset && run && (state_q == S_IDLE || state_q == S_FRAME_END);
  assign capture    = grid_ready && grid_valid;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_FRAME_END);
  assign sclk       = sclk_q;
  assign sdata      = sdata_q;
  assign slatch     = slatch_q;
  assign row_sel    = row_sel_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          buf_d   = grid_in;
          state_d = S_SHIFT;
          row_d   = 3'd0;
          bit_d   = 3'd0;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = S_LATCH;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = S_DWELL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DWELL: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d = '0;
          if (row_q == 3'd7) begin
            state_d = S_FRAME_END;
          end else begin
            row_d   = row_q + 3'd1;
            state_d = S_SHIFT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FRAME_END: begin
        if (run) begin
          state_d = S_SHIFT;
          row_d   = 3'd0;
          bit_d   = 3'd0;
          cnt_d   = '0;
          if (capture) buf_d = grid_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins come straight off flops.
  always_comb begin
    sclk_d    = 1'b0;
    sdata_d   = 1'b0;
    slatch_d  = 1'b0;
    row_sel_d = 8'h00;
    case (state_d)
      S_SHIFT: begin
        sclk_d  = (cnt_d >= CW'(CLK_DIV));
        sdata_d = buf_d[{row_d, ~bit_d}];
      end
      S_LATCH: slatch_d  = 1'b1;
      S_DWELL: row_sel_d = 8'b1 << row_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      row_q     <= 3'd0;
      bit_q     <= 3'd0;
      cnt_q     <= '0;
      buf_q     <= 64'd0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      slatch_q  <= 1'b0;
      row_sel_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      slatch_q  <= slatch_d;
      row_sel_q <= row_sel_d;
    end
  end

endmodule

// File: tb/tb_grid_display_tx.sv
// Bench for grid_display_tx: a frame-position model predicts every output each
// cycle, and directed literal checks pin the model to hand-computed values.
module tb_grid_display_tx;

  localparam int CD    = 2;
  localparam int DW    = 4;
  localparam int ROW   = 16 * CD + CD + DW;
  localparam int FRAME = 8 * ROW + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [63:0] grid_in = 64'd0;
  logic        grid_valid = 1'b0;
  logic        grid_ready, sclk, sdata, slatch, busy, frame_done;
  logic [7:0]  row_sel;

  int n_compared = 0;
  int n_mismatched = 0;

  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [63:0] m_buf = 64'd0;

  grid_display_tx #(.CLK_DIV(CD), .DWELL(DW)) dut (
    .clk(clk), .reset(reset), .run(run), .grid_in(grid_in),
    .grid_valid(grid_valid), .grid_ready(grid_ready), .sclk(sclk),
    .sdata(sdata), .slatch(slatch), .row_sel(row_sel), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: the display is either idle or at position m_t of a FRAME-cycle frame.
  always @(posedge clk) begin
    bit e_sclk, e_sdata, e_slatch, e_busy, e_done, e_ready, cap;
    logic [7:0] e_row;
    int r, off;
    if (!reset) begin
      m_active = 1'b0;
      m_t      = 0;
      m_buf    = 64'd0;
    end else begin
      cap = run && grid_valid && (!m_active || m_t == FRAME - 1);
      if (!m_active) begin
        if (cap) begin
          m_buf = grid_in; m_active = 1'b1; m_t = 0;
        end
      end else if (m_t == FRAME - 1) begin
        if (run) begin
          m_t = 0;
          if (cap) m_buf = grid_in;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_t++;
      end
    end
    #1;
    e_sclk = 0; e_sdata = 0; e_slatch = 0; e_busy = 0; e_done = 0; e_row = 8'h00;
    if (m_active) begin
      e_busy = 1;
      if (m_t == FRAME - 1) begin
        e_done = 1;
      end else begin
        r   = m_t / ROW;
        off = m_t % ROW;
        if (off < 16 * CD) begin
          e_sclk  = (off % (2 * CD)) >= CD;
          e_sdata = m_buf[r * 8 + 7 - off / (2 * CD)];
        end else if (off < 17 * CD) begin
          e_slatch = 1;
        end else begin
          e_row = 8'(1 << r);
        end
      end
    end
    e_ready = reset && run && (!m_active || m_t == FRAME - 1);
    check("sclk", sclk, e_sclk);
    check("sdata", sdata, e_sdata);
    check("slatch", slatch, e_slatch);
    check("row_sel", row_sel, e_row);
    check("busy", busy, e_busy);
    check("frame_done", frame_done, e_done);
    check("grid_ready", grid_ready, e_ready);
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 1000);
    if (!frame_done) check("frame_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic apply_stimulus(input logic [63:0] g);
    int n;
    grid_in = g;
    grid_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!grid_ready && n < 400);
    if (!grid_ready) check("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    grid_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [63:0] g;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_row_sel", row_sel, 0);
    reset = 1'b1;

    // idle with run low ignores valid data
    run = 1'b0; grid_valid = 1'b1; grid_in = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    check("idle_norun_ready", grid_ready, 0);
    check("idle_norun_busy", busy, 0);

    // first capture and row 0 bit stream
    run = 1'b1; grid_in = 64'h0000_0000_0000_0081;
    #1 check("idle_ready", grid_ready, 1);
    @(negedge clk);
    grid_valid = 1'b0;
    check("t0_sclk", sclk, 0);
    check("t0_sdata", sdata, 1);
    repeat (2) @(negedge clk);
    check("t2_sclk", sclk, 1);
    repeat (2) @(negedge clk);
    check("t4_sdata", sdata, 0);
    repeat (24) @(negedge clk);
    check("t28_sdata", sdata, 1);
    repeat (4) @(negedge clk);
    check("t32_slatch", slatch, 1);
    repeat (2) @(negedge clk);
    check("t34_row_sel", row_sel, 8'h01);
    repeat (4) @(negedge clk);
    check("t38_row_sel", row_sel, 8'h00);
    wait_done(n);
    check("first_done_dist", n, 266);
    wait_done(n);
    check("frame_period", n, 305);

    // mid-frame offer waits for FRAME_END
    repeat (100) @(negedge clk);
    grid_in = 64'hFF00_0000_0000_0000; grid_valid = 1'b1;
    #1 check("midframe_ready", grid_ready, 0);
    wait_done(n);
    check("offer_done_dist", n, 205);
    check("frame_end_ready", grid_ready, 1);
    @(negedge clk);
    grid_valid = 1'b0;
    check("new_row0_sdata", sdata, 0);
    repeat (266) @(negedge clk);
    check("new_row7_sdata", sdata, 1);

    // randomized grids offered at random points
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 300)) @(negedge clk);
      apply_stimulus({$urandom, $urandom});
    end

    // drop run during row 3
    wait_done(n);
    repeat (3 * ROW + 6) @(negedge clk);
    run = 1'b0;
    wait_done(n);
    @(negedge clk);
    check("stop_busy", busy, 0);
    check("stop_row_sel", row_sel, 0);
    g = {$urandom, $urandom};
    run = 1'b1; grid_in = g; grid_valid = 1'b1;
    @(negedge clk);
    grid_valid = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_sdata", sdata, g[7]);

    // async reset during row 5 latch
    repeat (5 * ROW + 32) @(negedge clk);
    check("row5_slatch", slatch, 1);
    #2 reset = 1'b0;
    #1;
    check("async_slatch", slatch, 0);
    check("async_busy", busy, 0);
    check("async_ready", grid_ready, 0);
    repeat (3) @(negedge clk);
    check("held_slatch", slatch, 0);
    reset = 1'b1;
    #1 check("release_ready", grid_ready, 1);
    repeat (5) @(negedge clk);
    check("release_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
